// File: rtl/ai_rd_dispatcher.sv
// AXI read dispatcher: one master port fanned out to SLV_AMT slaves.
// Slave select comes from the top address bits; unmapped selects are
// answered locally with DECERR bursts. R data returns strictly in AR order
// through a small order queue, so a slave that answers early is stalled
// until every older read has completed.
module ai_rd_dispatcher #(
    parameter int SLV_AMT           = 2,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_RD_RESP_W   = 2,
    parameter int SLV_SEL_W         = 2,
    parameter int OUTST_AMT         = 4
) (
    input  logic                                         ACLK_i,
    input  logic                                         ARESET_i,
    // master AR
    input  logic [0:TRANS_MST_ID_W-1]                    m_ARID_i,
    input  logic [0:ADDR_WIDTH-1]                        m_ARADDR_i,
    input  logic [0:TRANS_DATA_LEN_W-1]                  m_ARLEN_i,
    input  logic [0:TRANS_DATA_SIZE_W-1]                 m_ARSIZE_i,
    input  logic                                         m_ARVALID_i,
    output logic                                         m_ARREADY_o,
    // master R
    output logic [0:TRANS_MST_ID_W-1]                    m_RID_o,
    output logic [0:DATA_WIDTH-1]                        m_RDATA_o,
    output logic [0:TRANS_RD_RESP_W-1]                   m_RRESP_o,
    output logic                                         m_RLAST_o,
    output logic                                         m_RVALID_o,
    input  logic                                         m_RREADY_i,
    // slave AR (flattened, slave k at [k*W +: W])
    output logic [0:SLV_AMT*TRANS_MST_ID_W-1]            sa_ARID_o,
    output logic [0:SLV_AMT*ADDR_WIDTH-1]                sa_ARADDR_o,
    output logic [0:SLV_AMT*TRANS_DATA_LEN_W-1]          sa_ARLEN_o,
    output logic [0:SLV_AMT*TRANS_DATA_SIZE_W-1]         sa_ARSIZE_o,
    output logic [0:SLV_AMT-1]                           sa_ARVALID_o,
    input  logic [0:SLV_AMT-1]                           sa_ARREADY_i,
    // slave R
    input  logic [0:SLV_AMT*TRANS_MST_ID_W-1]            sa_RID_i,
    input  logic [0:SLV_AMT*DATA_WIDTH-1]                sa_RDATA_i,
    input  logic [0:SLV_AMT*TRANS_RD_RESP_W-1]           sa_RRESP_i,
    input  logic [0:SLV_AMT-1]                           sa_RLAST_i,
    input  logic [0:SLV_AMT-1]                           sa_RVALID_i,
    output logic [0:SLV_AMT-1]                           sa_RREADY_o,
    // status
    output logic [0:$clog2(OUTST_AMT)]                   outst_cnt_o,
    output logic                                         dsp_full_o
);
    localparam int PTR_W = (OUTST_AMT > 1) ? $clog2(OUTST_AMT) : 1;
    localparam int CNT_W = $clog2(OUTST_AMT) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST_AMT);

    typedef struct packed {
        logic                        err;
        logic [SLV_SEL_W-1:0]        sel;
        logic [TRANS_DATA_LEN_W-1:0] len;
        logic [TRANS_MST_ID_W-1:0]   id;
    } ord_t;

    ord_t                        ord_q [OUTST_AMT];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [CNT_W-1:0]            count;
    logic [TRANS_DATA_LEN_W-1:0] beat_cnt;

    logic [SLV_SEL_W-1:0] ar_sel;
    logic                 ar_decerr, ar_slv_rdy;
    logic                 push, pop, empty;
    ord_t                 head;

    assign ar_sel      = m_ARADDR_i[0:SLV_SEL_W-1];
    assign dsp_full_o  = (count == FULL_CNT);
    assign outst_cnt_o = count;
    assign empty       = (count == '0);
    assign head        = ord_q[rd_ptr];

    // AR fields go to every slave; only the selected one sees ARVALID
    genvar g;
    generate
        for (g = 0; g < SLV_AMT; g++) begin : g_ar_bcast
            assign sa_ARID_o  [g*TRANS_MST_ID_W    +: TRANS_MST_ID_W]    = m_ARID_i;
            assign sa_ARADDR_o[g*ADDR_WIDTH        +: ADDR_WIDTH]        = m_ARADDR_i;
            assign sa_ARLEN_o [g*TRANS_DATA_LEN_W  +: TRANS_DATA_LEN_W]  = m_ARLEN_i;
            assign sa_ARSIZE_o[g*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W] = m_ARSIZE_i;
        end
    endgenerate

    // address decode, AR valid steering and master AR ready
    always_comb begin
        ar_decerr    = 1'b1;
        ar_slv_rdy   = 1'b0;
        sa_ARVALID_o = '0;
        for (int k = 0; k < SLV_AMT; k++) begin
            if (ar_sel == k[SLV_SEL_W-1:0]) begin
                ar_decerr       = 1'b0;
                ar_slv_rdy      = sa_ARREADY_i[k];
                sa_ARVALID_o[k] = m_ARVALID_i & ~dsp_full_o;
            end
        end
        m_ARREADY_o = ~dsp_full_o & (ar_decerr | ar_slv_rdy);
    end

    assign push = m_ARVALID_i & m_ARREADY_o;

    // R return path: follow the queue head, either a slave or a local DECERR burst
    always_comb begin
        m_RID_o     = '0;
        m_RDATA_o   = '0;
        m_RRESP_o   = '0;
        m_RLAST_o   = 1'b0;
        m_RVALID_o  = 1'b0;
        sa_RREADY_o = '0;
        if (!empty) begin
            if (head.err) begin
                m_RVALID_o = 1'b1;
                m_RID_o    = head.id;
                m_RRESP_o  = '1;
                m_RLAST_o  = (beat_cnt == head.len);
            end else begin
                for (int k = 0; k < SLV_AMT; k++) begin
                    if (head.sel == k[SLV_SEL_W-1:0]) begin
                        m_RID_o        = sa_RID_i  [k*TRANS_MST_ID_W  +: TRANS_MST_ID_W];
                        m_RDATA_o      = sa_RDATA_i[k*DATA_WIDTH      +: DATA_WIDTH];
                        m_RRESP_o      = sa_RRESP_i[k*TRANS_RD_RESP_W +: TRANS_RD_RESP_W];
                        m_RLAST_o      = sa_RLAST_i[k];
                        m_RVALID_o     = sa_RVALID_i[k];
                        sa_RREADY_o[k] = m_RREADY_i;
                    end
                end
            end
        end
    end

    assign pop = m_RVALID_o & m_RREADY_i & m_RLAST_o;

    // order-queue storage; contents are don't-care until pushed
    always_ff @(posedge ACLK_i) begin
        if (push)
            ord_q[wr_ptr] <= '{err: ar_decerr, sel: ar_sel, len: m_ARLEN_i, id: m_ARID_i};
    end

    // pointers, occupancy and DECERR beat counter
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop)
                beat_cnt <= '0;
            else if (!empty && head.err && m_RREADY_i)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ai_rd_dispatcher.sv
// Directed bench for ai_rd_dispatcher with default parameters.
module tb_ai_rd_dispatcher;
    logic        ACLK_i = 1'b0;
    logic        ARESET_i;
    logic [0:4]  m_ARID_i;
    logic [0:31] m_ARADDR_i;
    logic [0:2]  m_ARLEN_i, m_ARSIZE_i;
    logic        m_ARVALID_i, m_ARREADY_o;
    logic [0:4]  m_RID_o;
    logic [0:31] m_RDATA_o;
    logic [0:1]  m_RRESP_o;
    logic        m_RLAST_o, m_RVALID_o, m_RREADY_i;
    logic [0:9]  sa_ARID_o;
    logic [0:63] sa_ARADDR_o;
    logic [0:5]  sa_ARLEN_o, sa_ARSIZE_o;
    logic [0:1]  sa_ARVALID_o, sa_ARREADY_i;
    logic [0:9]  sa_RID_i;
    logic [0:63] sa_RDATA_i;
    logic [0:3]  sa_RRESP_i;
    logic [0:1]  sa_RLAST_i, sa_RVALID_i, sa_RREADY_o;
    logic [0:2]  outst_cnt_o;
    logic        dsp_full_o;

    int checks = 0;
    int failures = 0;

    ai_rd_dispatcher dut (
        .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
        .m_ARID_i(m_ARID_i), .m_ARADDR_i(m_ARADDR_i), .m_ARLEN_i(m_ARLEN_i),
        .m_ARSIZE_i(m_ARSIZE_i), .m_ARVALID_i(m_ARVALID_i), .m_ARREADY_o(m_ARREADY_o),
        .m_RID_o(m_RID_o), .m_RDATA_o(m_RDATA_o), .m_RRESP_o(m_RRESP_o),
        .m_RLAST_o(m_RLAST_o), .m_RVALID_o(m_RVALID_o), .m_RREADY_i(m_RREADY_i),
        .sa_ARID_o(sa_ARID_o), .sa_ARADDR_o(sa_ARADDR_o), .sa_ARLEN_o(sa_ARLEN_o),
        .sa_ARSIZE_o(sa_ARSIZE_o), .sa_ARVALID_o(sa_ARVALID_o), .sa_ARREADY_i(sa_ARREADY_i),
        .sa_RID_i(sa_RID_i), .sa_RDATA_i(sa_RDATA_i), .sa_RRESP_i(sa_RRESP_i),
        .sa_RLAST_i(sa_RLAST_i), .sa_RVALID_i(sa_RVALID_i), .sa_RREADY_o(sa_RREADY_o),
        .outst_cnt_o(outst_cnt_o), .dsp_full_o(dsp_full_o)
    );

    always #5 ACLK_i = ~ACLK_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, land on the falling edge to drive new inputs
    task automatic step();
        @(posedge ACLK_i);
        @(negedge ACLK_i);
    endtask

    task automatic ar(input logic v, input logic [31:0] addr, input logic [4:0] id, input logic [2:0] len);
        m_ARVALID_i = v; m_ARADDR_i = addr; m_ARID_i = id; m_ARLEN_i = len; m_ARSIZE_i = 3'd2;
    endtask

    task automatic r_slv(input int k, input logic v, input logic last, input logic [4:0] id, input logic [31:0] d);
        sa_RVALID_i[k] = v; sa_RLAST_i[k] = last;
        sa_RID_i[k*5 +: 5] = id; sa_RDATA_i[k*32 +: 32] = d; sa_RRESP_i[k*2 +: 2] = 2'b00;
    endtask

    initial begin
        ARESET_i = 1'b1; m_RREADY_i = 1'b1; sa_ARREADY_i = 2'b00;
        sa_RID_i = '0; sa_RDATA_i = '0; sa_RRESP_i = '0; sa_RLAST_i = '0; sa_RVALID_i = '0;
        ar(1'b0, 32'h0, 5'd0, 3'd0);
        @(negedge ACLK_i);
        step();
        // reset state
        #1;
        chk("rst_cnt", outst_cnt_o, 0);
        chk("rst_full", dsp_full_o, 0);
        chk("rst_rvalid", m_RVALID_o, 0);
        chk("rst_rready", sa_RREADY_o, 2'b00);
        chk("rst_arready_busy", m_ARREADY_o, 0);
        sa_ARREADY_i = 2'b10; #1;
        chk("rst_arready_slv0", m_ARREADY_o, 1);
        chk("rst_rdata", m_RDATA_o, 0);
        ARESET_i = 1'b0;
        step();

        // single read to slave1, two beats
        ar(1'b1, 32'h4000_0000, 5'd1, 3'd1); sa_ARREADY_i = 2'b01; #1;
        chk("s1_arvalid", sa_ARVALID_o, 2'b01);
        chk("s1_arready", m_ARREADY_o, 1);
        chk("s1_bcast_addr0", sa_ARADDR_o[0:31], 32'h4000_0000);
        step();
        ar(1'b0, 32'h0, 5'd0, 3'd0); #1;
        chk("s1_cnt1", outst_cnt_o, 1);
        chk("s1_rready", sa_RREADY_o, 2'b01);
        chk("s1_idle_rvalid", m_RVALID_o, 0);
        r_slv(1, 1'b1, 1'b0, 5'd1, 32'hAAAA_0001); #1;
        chk("s1_b0_data", m_RDATA_o, 32'hAAAA_0001);
        chk("s1_b0_last", m_RLAST_o, 0);
        step();
        r_slv(1, 1'b1, 1'b1, 5'd1, 32'hAAAA_0002); #1;
        chk("s1_b1_data", m_RDATA_o, 32'hAAAA_0002);
        chk("s1_b1_id", m_RID_o, 1);
        chk("s1_b1_last", m_RLAST_o, 1);
        step();
        r_slv(1, 1'b0, 1'b0, 5'd0, 32'h0); #1;
        chk("s1_cnt0", outst_cnt_o, 0);
        chk("s1_empty_rvalid", m_RVALID_o, 0);

        // DECERR burst of 3 beats with a stall on the middle beat
        ar(1'b1, 32'h8000_0000, 5'd3, 3'd2); sa_ARREADY_i = 2'b00; #1;
        chk("de_arvalid", sa_ARVALID_o, 2'b00);
        chk("de_arready", m_ARREADY_o, 1);
        step();
        ar(1'b0, 32'h0, 5'd0, 3'd0); #1;
        chk("de_b0_valid", m_RVALID_o, 1);
        chk("de_b0_id", m_RID_o, 3);
        chk("de_b0_resp", m_RRESP_o, 2'b11);
        chk("de_b0_data", m_RDATA_o, 0);
        chk("de_b0_last", m_RLAST_o, 0);
        chk("de_rready", sa_RREADY_o, 2'b00);
        step();
        m_RREADY_i = 1'b0; #1;
        chk("de_b1_last", m_RLAST_o, 0);
        step();
        #1;
        chk("de_stall_valid", m_RVALID_o, 1);
        chk("de_stall_last", m_RLAST_o, 0);
        chk("de_stall_id", m_RID_o, 3);
        m_RREADY_i = 1'b1;
        step();
        #1;
        chk("de_b2_last", m_RLAST_o, 1);
        chk("de_b2_resp", m_RRESP_o, 2'b11);
        step();
        #1;
        chk("de_cnt0", outst_cnt_o, 0);

        // in-order return: slave0 then slave1, slave1 answers first
        sa_ARREADY_i = 2'b11;
        ar(1'b1, 32'h0000_0000, 5'd4, 3'd0);
        step();
        ar(1'b1, 32'h4000_0000, 5'd5, 3'd0);
        step();
        ar(1'b0, 32'h0, 5'd0, 3'd0);
        r_slv(1, 1'b1, 1'b1, 5'd5, 32'hB1B1_B1B1); #1;
        chk("oo_cnt2", outst_cnt_o, 2);
        chk("oo_stall_valid", m_RVALID_o, 0);
        chk("oo_rready", sa_RREADY_o, 2'b10);
        step();
        r_slv(0, 1'b1, 1'b1, 5'd4, 32'hA0A0_A0A0); #1;
        chk("oo_s0_data", m_RDATA_o, 32'hA0A0_A0A0);
        chk("oo_s0_id", m_RID_o, 4);
        step();
        r_slv(0, 1'b0, 1'b0, 5'd0, 32'h0); #1;
        chk("oo_s1_data", m_RDATA_o, 32'hB1B1_B1B1);
        chk("oo_s1_id", m_RID_o, 5);
        chk("oo_s1_rready", sa_RREADY_o, 2'b01);
        step();
        r_slv(1, 1'b0, 1'b0, 5'd0, 32'h0); #1;
        chk("oo_cnt0", outst_cnt_o, 0);

        // fill the queue; fifth AR held off even while a pop happens
        for (int i = 0; i < 4; i++) begin
            ar(1'b1, 32'h0000_0000, 5'(8 + i), 3'd0); #1;
            chk("fill_arready", m_ARREADY_o, 1);
            step();
        end
        #1;
        chk("full_flag", dsp_full_o, 1);
        chk("full_cnt", outst_cnt_o, 4);
        chk("full_arready", m_ARREADY_o, 0);
        chk("full_arvalid", sa_ARVALID_o, 2'b00);
        r_slv(0, 1'b1, 1'b1, 5'd8, 32'hC0C0_0000); #1;
        chk("full_pop_rvalid", m_RVALID_o, 1);
        chk("full_pop_arready", m_ARREADY_o, 0);
        step();
        r_slv(0, 1'b0, 1'b0, 5'd0, 32'h0); #1;
        chk("after_pop_cnt", outst_cnt_o, 3);
        chk("after_pop_full", dsp_full_o, 0);
        chk("after_pop_arready", m_ARREADY_o, 1);
        step();
        ar(1'b0, 32'h0, 5'd0, 3'd0); #1;
        chk("refill_cnt", outst_cnt_o, 4);
        r_slv(0, 1'b1, 1'b1, 5'd0, 32'hC0C0_0001);
        for (int i = 0; i < 4; i++) step();
        r_slv(0, 1'b0, 1'b0, 5'd0, 32'h0); #1;
        chk("drain_cnt", outst_cnt_o, 0);

        // reset mid-burst discards the entry
        ar(1'b1, 32'h0000_0000, 5'd7, 3'd3);
        step();
        ar(1'b0, 32'h0, 5'd0, 3'd0);
        r_slv(0, 1'b1, 1'b0, 5'd7, 32'hD0D0_0000); #1;
        chk("rb_b0_valid", m_RVALID_o, 1);
        step();
        ARESET_i = 1'b1;
        step();
        ARESET_i = 1'b0; #1;
        chk("rb_valid", m_RVALID_o, 0);
        chk("rb_cnt", outst_cnt_o, 0);
        chk("rb_rready", sa_RREADY_o, 2'b00);
        r_slv(0, 1'b0, 1'b0, 5'd0, 32'h0);
        ar(1'b1, 32'h4000_0000, 5'd9, 3'd0); sa_ARREADY_i = 2'b01; #1;
        chk("rb_new_arready", m_ARREADY_o, 1);
        chk("rb_new_arvalid", sa_ARVALID_o, 2'b01);
        step();
        ar(1'b0, 32'h0, 5'd0, 3'd0); #1;
        chk("rb_new_cnt", outst_cnt_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
